// File: rtl/decode_queue.sv
// ---------------------------------------------------------------------------
// decode_queue
//
// Instruction queue between fetch and issue. Each MIPS32 word is decoded as
// it is written, and the decoded control bundle is stored next to the word
// and its PC. The head entry is offered to the consumer with a valid/ready
// handshake. A branch or jump at the head is only offered once its delay-slot
// instruction sits behind it in the queue.
//
// Parameters
//    DEPTH        queue entries (power of two, >= 2)
//    SUPPORT_CP0  1 = decode MTC0/MFC0/ERET, 0 = every COP0 word is reserved
//    CNT_W        width of the occupancy count
//
// Ports
//    clk, rst         clock, synchronous active-high reset
//    flush            discard every entry (exception/redirect)
//    in_valid/ready   fetch handshake; in_instr, in_pc carry the word and PC
//    out_valid/ready  issue handshake on the head entry
//    out_instr/pc     head word and PC
//    out_*            decoded control bundle of the head entry
//    count            number of occupied entries
//
// Optional feature
//    DECODE_BYPASS_EN  when defined, a non-control instruction arriving at an
//                      empty queue is offered in the same cycle straight from
//                      the combinational decode; it is only written into the
//                      queue when the consumer does not take it.
// ---------------------------------------------------------------------------
module decode_queue #(
   parameter int DEPTH       = 4,
   parameter bit SUPPORT_CP0 = 1'b1,
   parameter int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_pc,
   output logic             out_regwrite,
   output logic [4:0]       out_dst,
   output logic             out_is_imm,
   output logic             out_sign_ex,
   output logic             out_mem_read,
   output logic             out_mem_write,
   output logic             out_memtoreg,
   output logic             out_hilotoreg,
   output logic             out_cp0_wen,
   output logic             out_cp0_to_reg,
   output logic [2:0]       out_br_cond,
   output logic             out_is_ctrl,
   output logic             out_ri,
   output logic             out_break,
   output logic             out_syscall,
   output logic             out_eret,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [31:0] ERET_WORD = 32'h4200_0018;

   typedef struct packed {
      logic       regWrite;
      logic [4:0] dst;
      logic       isImm;
      logic       signEx;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       hiLoToReg;
      logic       cp0Wen;
      logic       cp0ToReg;
      logic [2:0] brCond;
      logic       isCtrl;
      logic       ri;
      logic       brk;
      logic       sys;
      logic       eret;
   } ctrlBundle_t;

   ctrlBundle_t inDec;
   ctrlBundle_t headDec;
   ctrlBundle_t outDec;

   logic [5:0] inOp;
   logic [5:0] inFunct;
   logic [4:0] inRs;
   logic [4:0] inRt;
   logic [4:0] inRd;

   logic [31:0] instrMem [DEPTH];
   logic [31:0] pcMem    [DEPTH];
   ctrlBundle_t decMem   [DEPTH];

   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;

   logic notEmpty;
   logic queueValid;
   logic bypassActive;
   logic bypassTake;
   logic doPush;
   logic doPop;

   assign inOp    = in_instr[31:26];
   assign inRs    = in_instr[25:21];
   assign inRt    = in_instr[20:16];
   assign inRd    = in_instr[15:11];
   assign inFunct = in_instr[5:0];

   // Main decoder for the incoming word. Everything starts cleared so that
   // reserved words come out with only ri set (plus the extension select,
   // which depends purely on the opcode). Instructions that neither write a
   // GPR nor do anything special (MTHI, MULT, DIV, ...) fall through with an
   // all-zero bundle.
   always_comb begin
      inDec        = '0;
      inDec.signEx = (inOp[5:2] != 4'b0011);
      case (inOp)
         6'h00: begin
            case (inFunct)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2A, 6'h2B: begin
                  inDec.regWrite = 1'b1;
                  inDec.dst      = inRd;
               end
               6'h10, 6'h12: begin
                  inDec.regWrite  = 1'b1;
                  inDec.dst       = inRd;
                  inDec.hiLoToReg = 1'b1;
               end
               6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  inDec.regWrite = 1'b0;
               end
               6'h08: begin
                  inDec.isCtrl = 1'b1;
               end
               6'h09: begin
                  inDec.isCtrl   = 1'b1;
                  inDec.regWrite = 1'b1;
                  inDec.dst      = 5'd31;
               end
               6'h0C: begin
                  inDec.sys = 1'b1;
               end
               6'h0D: begin
                  inDec.brk = 1'b1;
               end
               default: begin
                  inDec.ri = 1'b1;
               end
            endcase
         end
         6'h01: begin
            case (inRt)
               5'h00: begin
                  inDec.isCtrl = 1'b1;
                  inDec.brCond = 3'b101;
               end
               5'h01: begin
                  inDec.isCtrl = 1'b1;
                  inDec.brCond = 3'b110;
               end
               5'h10: begin
                  inDec.isCtrl   = 1'b1;
                  inDec.brCond   = 3'b101;
                  inDec.regWrite = 1'b1;
                  inDec.dst      = 5'd31;
               end
               5'h11: begin
                  inDec.isCtrl   = 1'b1;
                  inDec.brCond   = 3'b110;
                  inDec.regWrite = 1'b1;
                  inDec.dst      = 5'd31;
               end
               default: begin
                  inDec.ri = 1'b1;
               end
            endcase
         end
         6'h02: begin
            inDec.isCtrl = 1'b1;
         end
         6'h03: begin
            inDec.isCtrl   = 1'b1;
            inDec.regWrite = 1'b1;
            inDec.dst      = 5'd31;
         end
         6'h04: begin
            inDec.isCtrl = 1'b1;
            inDec.brCond = 3'b001;
         end
         6'h05: begin
            inDec.isCtrl = 1'b1;
            inDec.brCond = 3'b010;
         end
         6'h06: begin
            inDec.isCtrl = 1'b1;
            inDec.brCond = 3'b011;
         end
         6'h07: begin
            inDec.isCtrl = 1'b1;
            inDec.brCond = 3'b100;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            inDec.isImm    = 1'b1;
            inDec.regWrite = 1'b1;
            inDec.dst      = inRt;
         end
         6'h10: begin
            if (SUPPORT_CP0) begin
               if (in_instr == ERET_WORD) begin
                  inDec.eret = 1'b1;
               end else if (inRs == 5'h00) begin
                  inDec.regWrite = 1'b1;
                  inDec.dst      = inRt;
                  inDec.cp0ToReg = 1'b1;
               end else if (inRs == 5'h04) begin
                  inDec.cp0Wen = 1'b1;
               end else begin
                  inDec.ri = 1'b1;
               end
            end else begin
               inDec.ri = 1'b1;
            end
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            inDec.isImm    = 1'b1;
            inDec.regWrite = 1'b1;
            inDec.dst      = inRt;
            inDec.memRead  = 1'b1;
            inDec.memToReg = 1'b1;
         end
         6'h28, 6'h29, 6'h2B: begin
            inDec.isImm    = 1'b1;
            inDec.memWrite = 1'b1;
         end
         default: begin
            inDec.ri = 1'b1;
         end
      endcase
   end

   // The head is issuable when something is queued, except that a control
   // transfer waits until its delay slot is queued behind it.
   assign notEmpty   = (count != '0);
   assign headDec    = decMem[rdPtr];
   assign queueValid = notEmpty & ~(headDec.isCtrl & (count < CNT_W'(2)));
   assign in_ready   = (count != CNT_W'(DEPTH));

`ifdef DECODE_BYPASS_EN
   assign bypassActive = ~rst & ~notEmpty & in_valid & ~flush & ~inDec.isCtrl;
`else
   assign bypassActive = 1'b0;
`endif

   // A bypassed word that the consumer takes never touches the storage;
   // otherwise it is written like any other push. Flush discards the push.
   assign bypassTake = bypassActive & out_ready;
   assign out_valid  = queueValid | bypassActive;
   assign doPush     = in_valid & in_ready & ~flush & ~bypassTake;
   assign doPop      = queueValid & out_ready;

   // Output selection: bypassed decode, stored head, or all zero when the
   // queue is empty. No decoding happens on this path for stored entries.
   always_comb begin
      outDec    = '0;
      out_instr = '0;
      out_pc    = '0;
      if (bypassActive) begin
         outDec    = inDec;
         out_instr = in_instr;
         out_pc    = in_pc;
      end else if (notEmpty) begin
         outDec    = headDec;
         out_instr = instrMem[rdPtr];
         out_pc    = pcMem[rdPtr];
      end
   end

   assign out_regwrite   = outDec.regWrite;
   assign out_dst        = outDec.dst;
   assign out_is_imm     = outDec.isImm;
   assign out_sign_ex    = outDec.signEx;
   assign out_mem_read   = outDec.memRead;
   assign out_mem_write  = outDec.memWrite;
   assign out_memtoreg   = outDec.memToReg;
   assign out_hilotoreg  = outDec.hiLoToReg;
   assign out_cp0_wen    = outDec.cp0Wen;
   assign out_cp0_to_reg = outDec.cp0ToReg;
   assign out_br_cond    = outDec.brCond;
   assign out_is_ctrl    = outDec.isCtrl;
   assign out_ri         = outDec.ri;
   assign out_break      = outDec.brk;
   assign out_syscall    = outDec.sys;
   assign out_eret       = outDec.eret;

   // Storage write port. The arrays need no reset because every read of
   // them is qualified by the occupancy count.
   always_ff @(posedge clk) begin
      if (doPush) begin
         instrMem[wrPtr] <= in_instr;
         pcMem[wrPtr]    <= in_pc;
         decMem[wrPtr]   <= inDec;
      end
   end

   // Pointer and occupancy bookkeeping. Reset beats flush, flush beats any
   // push or pop. Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_decode_queue
//
// Bench for decode_queue. The driver pushes the expected decoded entry onto a
// scoreboard queue whenever the queue model says a push will be accepted; the
// monitor samples on the falling edge, checks handshake/count against the
// model and compares the head bundle whenever an output is expected. A second
// instance with SUPPORT_CP0 = 0 shares the same stimulus for the COP0 checks.
// Honours DECODE_BYPASS_EN for the same-cycle bypass behaviour.
// ---------------------------------------------------------------------------
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        regWrite;
      logic [4:0]  dst;
      logic        isImm;
      logic        signEx;
      logic        memRead;
      logic        memWrite;
      logic        memToReg;
      logic        hiLoToReg;
      logic        cp0Wen;
      logic        cp0ToReg;
      logic [2:0]  brCond;
      logic        isCtrl;
      logic        ri;
      logic        brk;
      logic        sys;
      logic        eret;
   } expEntry_t;

   typedef enum {
      K_RALU, K_HILO, K_NOWB, K_IALU, K_LOAD, K_STORE, K_BRANCH, K_BRLINK,
      K_JUMP, K_JUMPLINK, K_JR, K_MFC0, K_MTC0, K_ERET, K_SYSCALL, K_BREAK,
      K_RESERVED
   } kind_t;

   logic clock = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic inValid = 1'b0;
   logic [31:0] inInstr = '0;
   logic [31:0] inPc = '0;
   logic outReady = 1'b0;

   logic inReady, outValid;
   logic [31:0] outInstr, outPc;
   logic outRegwrite, outIsImm, outSignEx, outMemRead, outMemWrite;
   logic outMemtoreg, outHilotoreg, outCp0Wen, outCp0ToReg, outIsCtrl;
   logic outRi, outBreak, outSyscall, outEret;
   logic [4:0] outDst;
   logic [2:0] outBrCond;
   logic [CNT_W-1:0] count;

   logic zInReady, zOutValid;
   logic [31:0] zOutInstr, zOutPc;
   logic zOutRegwrite, zOutIsImm, zOutSignEx, zOutMemRead, zOutMemWrite;
   logic zOutMemtoreg, zOutHilotoreg, zOutCp0Wen, zOutCp0ToReg, zOutIsCtrl;
   logic zOutRi, zOutBreak, zOutSyscall, zOutEret;
   logic [4:0] zOutDst;
   logic [2:0] zOutBrCond;
   logic [CNT_W-1:0] zCount;

   int checks = 0;
   int errors = 0;
   int pushCount = 0;
   int seenPush = 0;
   expEntry_t expQ[$];
   expEntry_t actual;
   logic [31:0] pcNext = 32'h0040_0000;

   always #5 clock = ~clock;

   decode_queue #(.DEPTH(DEPTH), .SUPPORT_CP0(1'b1)) dut (
      .clk(clock), .rst(rst), .flush(flush),
      .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_pc(inPc),
      .out_valid(outValid), .out_ready(outReady),
      .out_instr(outInstr), .out_pc(outPc),
      .out_regwrite(outRegwrite), .out_dst(outDst), .out_is_imm(outIsImm),
      .out_sign_ex(outSignEx), .out_mem_read(outMemRead),
      .out_mem_write(outMemWrite), .out_memtoreg(outMemtoreg),
      .out_hilotoreg(outHilotoreg), .out_cp0_wen(outCp0Wen),
      .out_cp0_to_reg(outCp0ToReg), .out_br_cond(outBrCond),
      .out_is_ctrl(outIsCtrl), .out_ri(outRi), .out_break(outBreak),
      .out_syscall(outSyscall), .out_eret(outEret), .count(count)
   );

   decode_queue #(.DEPTH(DEPTH), .SUPPORT_CP0(1'b0)) dutNoCp0 (
      .clk(clock), .rst(rst), .flush(flush),
      .in_valid(inValid), .in_ready(zInReady), .in_instr(inInstr), .in_pc(inPc),
      .out_valid(zOutValid), .out_ready(outReady),
      .out_instr(zOutInstr), .out_pc(zOutPc),
      .out_regwrite(zOutRegwrite), .out_dst(zOutDst), .out_is_imm(zOutIsImm),
      .out_sign_ex(zOutSignEx), .out_mem_read(zOutMemRead),
      .out_mem_write(zOutMemWrite), .out_memtoreg(zOutMemtoreg),
      .out_hilotoreg(zOutHilotoreg), .out_cp0_wen(zOutCp0Wen),
      .out_cp0_to_reg(zOutCp0ToReg), .out_br_cond(zOutBrCond),
      .out_is_ctrl(zOutIsCtrl), .out_ri(zOutRi), .out_break(zOutBreak),
      .out_syscall(zOutSyscall), .out_eret(zOutEret), .count(zCount)
   );

   // Pack the main DUT's head outputs into the scoreboard format.
   always_comb begin
      actual = '{outInstr, outPc, outRegwrite, outDst, outIsImm, outSignEx,
                 outMemRead, outMemWrite, outMemtoreg, outHilotoreg, outCp0Wen,
                 outCp0ToReg, outBrCond, outIsCtrl, outRi, outBreak,
                 outSyscall, outEret};
   end

   // Instruction classes straight from the MIPS32 opcode map.
   function automatic kind_t classify(input logic [31:0] w, input bit cp0);
      logic [5:0] op = w[31:26];
      logic [5:0] fn = w[5:0];
      logic [4:0] rs = w[25:21];
      logic [4:0] rt = w[20:16];
      if (op == 6'd0) begin
         if (fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, [6'd32:6'd39], 6'd42, 6'd43})
            return K_RALU;
         if (fn inside {6'd16, 6'd18}) return K_HILO;
         if (fn inside {6'd17, 6'd19, [6'd24:6'd27]}) return K_NOWB;
         if (fn == 6'd8) return K_JR;
         if (fn == 6'd9) return K_JUMPLINK;
         if (fn == 6'd12) return K_SYSCALL;
         if (fn == 6'd13) return K_BREAK;
         return K_RESERVED;
      end
      if (op == 6'd1) begin
         if (rt inside {5'd0, 5'd1}) return K_BRANCH;
         if (rt inside {5'd16, 5'd17}) return K_BRLINK;
         return K_RESERVED;
      end
      if (op == 6'd2) return K_JUMP;
      if (op == 6'd3) return K_JUMPLINK;
      if (op inside {[6'd4:6'd7]}) return K_BRANCH;
      if (op inside {[6'd8:6'd15]}) return K_IALU;
      if (op == 6'd16) begin
         if (!cp0) return K_RESERVED;
         if (w == 32'h4200_0018) return K_ERET;
         if (rs == 5'd0) return K_MFC0;
         if (rs == 5'd4) return K_MTC0;
         return K_RESERVED;
      end
      if (op inside {6'd32, 6'd33, 6'd35, 6'd36, 6'd37}) return K_LOAD;
      if (op inside {6'd40, 6'd41, 6'd43}) return K_STORE;
      return K_RESERVED;
   endfunction

   // Expected head bundle derived from the instruction class.
   function automatic expEntry_t refDecode(input logic [31:0] w, input logic [31:0] pc);
      expEntry_t e = '0;
      kind_t k = classify(w, 1'b1);
      e.instr = w;
      e.pc = pc;
      e.regWrite = k inside {K_RALU, K_HILO, K_IALU, K_LOAD, K_BRLINK, K_JUMPLINK, K_MFC0};
      if (k inside {K_RALU, K_HILO}) e.dst = w[15:11];
      else if (k inside {K_IALU, K_LOAD, K_MFC0}) e.dst = w[20:16];
      else if (k inside {K_BRLINK, K_JUMPLINK}) e.dst = 5'd31;
      e.isImm = k inside {K_IALU, K_LOAD, K_STORE};
      e.signEx = (w[31:28] != 4'b0011);
      e.memRead = (k == K_LOAD);
      e.memToReg = (k == K_LOAD);
      e.memWrite = (k == K_STORE);
      e.hiLoToReg = (k == K_HILO);
      e.cp0Wen = (k == K_MTC0);
      e.cp0ToReg = (k == K_MFC0);
      e.isCtrl = k inside {K_BRANCH, K_BRLINK, K_JUMP, K_JUMPLINK, K_JR};
      if (k inside {K_BRANCH, K_BRLINK}) begin
         if (w[31:26] == 6'd1) e.brCond = w[16] ? 3'b110 : 3'b101;
         else e.brCond = 3'(w[31:26] - 6'd3);
      end
      e.ri = (k == K_RESERVED);
      e.brk = (k == K_BREAK);
      e.sys = (k == K_SYSCALL);
      e.eret = (k == K_ERET);
      return e;
   endfunction

   function automatic logic [31:0] randInstr();
      logic [31:0] w = $urandom();
      int pick = $urandom_range(0, 9);
      case (pick)
         0: ;
         1: w[31:26] = 6'd0;
         2: begin
            w[31:26] = 6'd0;
            case ($urandom_range(0, 3))
               0: w[5:0] = 6'h21;
               1: w[5:0] = 6'h10;
               2: w[5:0] = 6'h09;
               default: w[5:0] = 6'h08;
            endcase
         end
         3: begin
            w[31:26] = 6'd1;
            case ($urandom_range(0, 4))
               0: w[20:16] = 5'd0;
               1: w[20:16] = 5'd1;
               2: w[20:16] = 5'd16;
               3: w[20:16] = 5'd17;
               default: ;
            endcase
         end
         4: w[31:26] = 6'($urandom_range(2, 7));
         5: w[31:26] = 6'($urandom_range(8, 15));
         6: w[31:26] = 6'($urandom_range(32, 43));
         7: begin
            w[31:26] = 6'h10;
            case ($urandom_range(0, 3))
               0: w[25:21] = 5'd0;
               1: w[25:21] = 5'd4;
               2: w = 32'h4200_0018;
               default: ;
            endcase
         end
         8: w = 32'h0;
         default: w[31:26] = 6'h3F;
      endcase
      return w;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] got,
                              input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge and record the
   // expected entry if the model says the push will be accepted.
   task automatic applyStimulus(input logic v, input logic [31:0] w,
                                input logic rdy, input logic fl);
      @(posedge clock);
      #1;
      inValid = v;
      inInstr = w;
      inPc = pcNext;
      outReady = rdy;
      flush = fl;
      if (v && !fl && !rst && expQ.size() < DEPTH) begin
         expQ.push_back(refDecode(w, pcNext));
         pushCount++;
      end
      if (v) pcNext = pcNext + 32'd4;
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(1'b0, 32'h0, rdy, 1'b0);
   endtask

   // Monitor: handshake and count against the model, head bundle against the
   // scoreboard whenever an output is expected, all zero when empty.
   always @(negedge clock) begin
      int c;
      bit expValid;
      bit bypassExp;
      if (rst) begin
         expQ.delete();
      end else begin
         c = expQ.size() - (pushCount - seenPush);
         bypassExp = 1'b0;
`ifdef DECODE_BYPASS_EN
         bypassExp = (c == 0) && inValid && !flush && !refDecode(inInstr, inPc).isCtrl;
`endif
         expValid = bypassExp || (c >= 1 && !(expQ[0].isCtrl && c < 2));
         checkOutput("count", 128'(count), 128'(c));
         checkOutput("in_ready", 128'(inReady), 128'(c != DEPTH));
         checkOutput("out_valid", 128'(outValid), 128'(expValid));
         if (expValid) begin
            checkOutput("head_bundle", 128'(actual), 128'(expQ[0]));
            if (outReady) void'(expQ.pop_front());
         end else if (c == 0) begin
            checkOutput("empty_outputs", 128'(actual), 128'(0));
         end
         if (flush) expQ.delete();
      end
      seenPush = pushCount;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      rst = 1'b0;
      idle(1'b0);
      @(negedge clock);
      checkOutput("reset_in_ready", 128'(inReady), 128'(1));

      // ADDIU $8,$9,0x8000
      applyStimulus(1'b1, 32'h2528_8000, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clock);
      checkOutput("addiu_dst", 128'(outDst), 128'(8));
      checkOutput("addiu_flags", 128'({outIsImm, outSignEx, outRegwrite}), 128'(3'b111));
      checkOutput("addiu_count", 128'(count), 128'(1));
      idle(1'b1);

      // BEQ waits for its delay slot
      applyStimulus(1'b1, 32'h1109_0003, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         @(negedge clock);
         checkOutput("beq_stall", 128'(outValid), 128'(0));
      end
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clock);
      checkOutput("beq_release", 128'({outValid, outBrCond, outIsCtrl}), 128'(5'b1_001_1));
      idle(1'b1);
      idle(1'b1);

      // Fill to DEPTH, ignored extra push, one pop frees a slot
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h2408_0000 + i, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clock);
      checkOutput("full_in_ready", 128'(inReady), 128'(0));
      checkOutput("full_count", 128'(count), 128'(DEPTH));
      applyStimulus(1'b1, 32'h2408_00FF, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b0);
      @(negedge clock);
      checkOutput("after_pop_in_ready", 128'(inReady), 128'(1));
      repeat (DEPTH) idle(1'b1);
      for (int i = 0; i < 3 * DEPTH; i++)
         applyStimulus(1'b1, 32'h2409_0000 + i, 1'($urandom_range(0, 1)), 1'b0);
      repeat (3 * DEPTH) idle(1'b1);

      // Flush with a simultaneous push
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h240A_0000 + i, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h240A_00EE, 1'b0, 1'b1);
      idle(1'b0);
      @(negedge clock);
      checkOutput("flush_count", 128'(count), 128'(0));
      checkOutput("flush_valid", 128'(outValid), 128'(0));

      // JAL + NOP, reserved opcode, MFC0 with and without CP0 support
      applyStimulus(1'b1, 32'h0C00_0010, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clock);
      checkOutput("jal_dst", 128'({outDst, outRegwrite}), 128'({5'd31, 1'b1}));
      idle(1'b1);
      idle(1'b1);
      applyStimulus(1'b1, 32'hFC00_0000, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clock);
      checkOutput("ri_op3f", 128'({outRi, outRegwrite}), 128'(2'b10));
      idle(1'b1);
      applyStimulus(1'b1, 32'h4008_6000, 1'b0, 1'b0);
      idle(1'b0);
      @(negedge clock);
      checkOutput("mfc0_cp0", 128'({outRi, outCp0ToReg, outDst}), 128'({2'b01, 5'd8}));
      checkOutput("mfc0_nocp0", 128'({zOutRi, zOutRegwrite}), 128'(2'b10));
      idle(1'b1);

`ifdef DECODE_BYPASS_EN
      applyStimulus(1'b1, 32'h3528_0001, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("bypass_valid", 128'({outValid, count}), 128'({1'b1, CNT_W'(0)}));
      idle(1'b1);
      applyStimulus(1'b1, 32'h0800_0000, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("bypass_j", 128'(outValid), 128'(0));
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
`endif

      // Reset mid-stream drops everything
      applyStimulus(1'b1, 32'h240B_0001, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h240B_0002, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      inValid = 1'b0;
      rst = 1'b1;
      @(posedge clock);
      #1;
      rst = 1'b0;
      @(negedge clock);
      checkOutput("midreset_count", 128'(count), 128'(0));

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 70), randInstr(),
                       1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 3));
      end
      repeat (4) idle(1'b1);
      @(negedge clock);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
